load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning width of data, address and memory data ports.
REQ-002 SHALL have port in_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port in_rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_req_valid, input, 1, core request strobe.
REQ-005 SHALL have port out_req_ready, output, 1, unit can accept a request.
REQ-006 SHALL have port in_req_we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port in_funct3, input, 3, RV64 size/sign code.
REQ-008 SHALL have port in_addr, input, DATA_WIDTH, byte address.
REQ-009 SHALL have port in_wdata, input, DATA_WIDTH, store data, right-aligned.
REQ-010 SHALL have port out_resp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port out_resp_err, output, 1, illegal funct3, valid with out_resp_valid.
REQ-012 SHALL have port out_rdata, output, DATA_WIDTH, extended load result.
REQ-013 SHALL have port out_mem_addr, output, DATA_WIDTH, byte address to data memory.
REQ-014 SHALL have port out_mem_wdata, output, DATA_WIDTH, 8-byte little-endian write data.
REQ-015 SHALL have port out_mem_wr_en, output, 1, memory write enable, registered.
REQ-016 SHALL have port in_mem_rdata, input, DATA_WIDTH, 8 bytes at out_mem_addr, combinational, little-endian.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-018 In IDLE, out_req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-019 SHALL latch addr, we, funct3 and wdata on the edge where in_req_valid=1 in IDLE, then go to READ.
REQ-020 SHALL ignore in_req_valid when not in IDLE, with no state change.
REQ-021 In READ, SHALL drive out_mem_addr = latched addr and out_mem_wr_en = 0, and capture in_mem_rdata.
REQ-022 From READ, a legal load SHALL go to RESP, a legal store to WRITE, and any illegal code to RESP with err = 1.
REQ-023 Legal loads SHALL be 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; 111 is illegal.
REQ-024 Legal stores SHALL be 000 SB, 001 SH, 010 SW, 011 SD; 1xx is illegal.
REQ-025 Loads SHALL take the low 1/2/4/8 bytes of the captured data, sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to 64 bits.
REQ-026 Stores SHALL merge into the captured data: low 1/2/4/8 bytes from wdata, remaining bytes unchanged.
REQ-027 In WRITE, SHALL assert out_mem_wr_en for exactly one cycle, with addr and merged wdata stable that whole cycle; then go to RESP.
REQ-028 out_mem_wr_en SHALL never be 1 outside WRITE, and never for illegal codes.
REQ-029 In RESP, SHALL pulse out_resp_valid for one cycle, then return to IDLE.
REQ-030 out_rdata SHALL be the load result for loads and 0 for stores or errors; it holds until the next RESP.
REQ-031 Latency, with acceptance at edge T: a load SHALL give resp_valid in cycle T+2; a store SHALL write in T+2 and give resp_valid in T+3.
REQ-032 A new request SHALL be accepted no earlier than the cycle after RESP.
REQ-033 Addresses SHALL pass through unmodified: no alignment check and no wrap handling; byte granularity is memory-side.

Reset
REQ-034 in_rst=1 at an edge SHALL force IDLE, out_resp_valid=0, out_resp_err=0, out_rdata=0, out_mem_wr_en=0, out_mem_addr=0, out_mem_wdata=0.
REQ-035 Reset during READ SHALL prevent any write; reset during WRITE SHALL drop wr_en at that edge with no response.
REQ-036 Reset SHALL take priority over a simultaneous in_req_valid.

Structure
REQ-037 Shared package lsu_pkg SHALL hold the state encoding, funct3 constants and size decode.
REQ-038 Combinational sub-module lsu_align SHALL implement extension (REQ-025) and merge (REQ-026); FSM and registers stay in load_store_unit.

Verification
REQ-039 Memory pre-set 0x1122334455667788 at 0x100; LB 0x100 -> rdata 0xFFFFFFFFFFFFFF88 at T+2; LBU -> 0x88.
REQ-040 Same memory; SH 0x100 with wdata 0xABCD -> one wr_en pulse at T+2, memory 0x112233445566ABCD, resp at T+3.
REQ-041 LW 0x104 after SD 0x80000000FFFFFFFF at 0x100 -> 0xFFFFFFFF80000000; LWU -> 0x80000000.
REQ-042 Store with funct3 100 -> resp_valid and err = 1 at T+2, no wr_en, memory unchanged.
REQ-043 in_req_valid held high back-to-back -> second request accepted only after RESP, ready = 0 while busy.
REQ-044 Reset asserted in READ of a store -> no wr_en pulse, no resp, IDLE and ready = 1 next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, RV64 size codes
// and the size/legality decode used by the FSM and the data aligner.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // The low two bits select the access size; bit 2 only flags zero-extension.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic load_legal(input logic [2:0] funct3);
        return funct3 != 3'b111;
    endfunction

    function automatic logic store_legal(input logic [2:0] funct3);
        return !funct3[2];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path: extends loaded bytes to a full word and merges
// store bytes into the word read back from memory.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] store_data
);

    logic [3:0] nbytes;

    assign nbytes = size_bytes(funct3);

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:  load_data = {{(DATA_WIDTH-8){mem_data[7]}}, mem_data[7:0]};
            F3_H:  load_data = {{(DATA_WIDTH-16){mem_data[15]}}, mem_data[15:0]};
            F3_W:  load_data = {{(DATA_WIDTH-32){mem_data[31]}}, mem_data[31:0]};
            F3_D:  load_data = mem_data;
            F3_BU: load_data = {{(DATA_WIDTH-8){1'b0}}, mem_data[7:0]};
            F3_HU: load_data = {{(DATA_WIDTH-16){1'b0}}, mem_data[15:0]};
            F3_WU: load_data = {{(DATA_WIDTH-32){1'b0}}, mem_data[31:0]};
            default: load_data = '0;
        endcase
    end

    // Bytes above the access size keep whatever memory already holds.
    always_comb begin
        store_data = mem_data;
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (i < int'(nbytes))
                store_data[i*8 +: 8] = wdata[i*8 +: 8];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: read-modify-write sequencer between the core request port
// and a combinational-read, registered-write data memory.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// ST_IDLE  | ready for a request; latch it when in_req_valid is seen
// ST_READ  | present address, capture memory word, decode legality
// ST_WRITE | one-cycle write of the merged word (legal stores only)
// ST_RESP  | one-cycle response pulse, then back to idle
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_req_valid,
    output logic                  out_req_ready,
    input  logic                  in_req_we,
    input  logic [2:0]            in_funct3,
    input  logic [DATA_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    output logic                  out_resp_valid,
    output logic                  out_resp_err,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic [DATA_WIDTH-1:0] out_mem_addr,
    output logic [DATA_WIDTH-1:0] out_mem_wdata,
    output logic                  out_mem_wr_en,
    input  logic [DATA_WIDTH-1:0] in_mem_rdata
);

    lsu_state_t            state, state_next;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic                  err_next;
    logic [DATA_WIDTH-1:0] load_data, store_data;

    assign out_mem_addr = addr_q;

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3     (funct3_q),
        .mem_data   (in_mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_comb begin
        state_next    = state;
        out_req_ready = 1'b0;
        err_next      = 1'b0;
        case (state)
            ST_IDLE: begin
                out_req_ready = 1'b1;
                if (in_req_valid)
                    state_next = ST_READ;
            end
            ST_READ: begin
                err_next   = we_q ? !store_legal(funct3_q) : !load_legal(funct3_q);
                state_next = (we_q && !err_next) ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state          <= ST_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            we_q           <= 1'b0;
            funct3_q       <= '0;
            out_resp_valid <= 1'b0;
            out_resp_err   <= 1'b0;
            out_rdata      <= '0;
            out_mem_wdata  <= '0;
            out_mem_wr_en  <= 1'b0;
        end else begin
            state          <= state_next;
            out_mem_wr_en  <= (state_next == ST_WRITE);
            out_resp_valid <= (state_next == ST_RESP);
            if (state == ST_IDLE && in_req_valid) begin
                addr_q   <= in_addr;
                wdata_q  <= in_wdata;
                we_q     <= in_req_we;
                funct3_q <= in_funct3;
            end
            // Result registers change only on the edge entering RESP so they hold between responses.
            if (state == ST_READ) begin
                if (state_next == ST_WRITE) begin
                    out_mem_wdata <= store_data;
                end else begin
                    out_rdata    <= (err_next || we_q) ? '0 : load_data;
                    out_resp_err <= err_next;
                end
            end
            if (state == ST_WRITE) begin
                out_rdata    <= '0;
                out_resp_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// responses/writes; a negedge monitor pops and compares them.
module tb_load_store_unit;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_req_valid;
    logic        out_req_ready;
    logic        in_req_we;
    logic [2:0]  in_funct3;
    logic [63:0] in_addr, in_wdata;
    logic        out_resp_valid, out_resp_err;
    logic [63:0] out_rdata, out_mem_addr, out_mem_wdata;
    logic        out_mem_wr_en;
    logic [63:0] in_mem_rdata;

    always #5 in_clk = ~in_clk;

    load_store_unit #(.DATA_WIDTH(64)) dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_req_valid   (in_req_valid),
        .out_req_ready  (out_req_ready),
        .in_req_we      (in_req_we),
        .in_funct3      (in_funct3),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .out_resp_valid (out_resp_valid),
        .out_resp_err   (out_resp_err),
        .out_rdata      (out_rdata),
        .out_mem_addr   (out_mem_addr),
        .out_mem_wdata  (out_mem_wdata),
        .out_mem_wr_en  (out_mem_wr_en),
        .in_mem_rdata   (in_mem_rdata)
    );

    typedef struct { longint cyc; logic err; logic [63:0] rdata; } resp_t;
    typedef struct { longint cyc; logic [63:0] addr; logic [63:0] data; } wr_t;

    resp_t  resp_q[$];
    wr_t    wr_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    longint cyc      = 0;
    logic [7:0] mem [4096];

    always @(posedge in_clk) cyc <= cyc + 1;

    function automatic logic [63:0] word_at(input logic [63:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = mem[(a[11:0] + 12'(i)) & 12'hFFF];
        return w;
    endfunction

    always_comb in_mem_rdata = word_at(out_mem_addr);

    always @(posedge in_clk) begin
        if (out_mem_wr_en)
            for (int i = 0; i < 8; i++)
                mem[(out_mem_addr[11:0] + 12'(i)) & 12'hFFF] <= out_mem_wdata[i*8 +: 8];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge in_clk) begin
        if (out_resp_valid === 1'b1) begin
            if (resp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                chk("resp_cycle", 64'(cyc), 64'(r.cyc));
                chk("resp_err", 64'(out_resp_err), 64'(r.err));
                chk("resp_rdata", out_rdata, r.rdata);
            end
        end
        if (out_mem_wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_wr: got wr_en=1 addr=0x%016h expected none (cycle %0d)", out_mem_addr, cyc);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("wr_cycle", 64'(cyc), 64'(w.cyc));
                chk("wr_addr", out_mem_addr, w.addr);
                chk("wr_data", out_mem_wdata, w.data);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the READ cycle.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic exp_wr, input logic [63:0] exp_wdata,
                         input logic exp_err, input logic [63:0] exp_rdata,
                         input logic push, input logic hold, output longint t_acc);
        in_req_valid = 1'b1;
        in_req_we    = we;
        in_funct3    = f3;
        in_addr      = a;
        in_wdata     = wd;
        t_acc        = -1;
        for (int k = 0; k < 20 && out_req_ready !== 1'b1; k++) @(negedge in_clk);
        chk("req_ready", 64'(out_req_ready), 64'd1);
        if (out_req_ready !== 1'b1) begin
            in_req_valid = 1'b0;
            return;
        end
        t_acc = cyc;
        if (push) begin
            if (exp_wr) wr_q.push_back('{t_acc + 2, a, exp_wdata});
            resp_q.push_back('{exp_wr ? t_acc + 3 : t_acc + 2, exp_err, exp_rdata});
        end
        @(posedge in_clk);
        @(negedge in_clk);
        if (!hold) in_req_valid = 1'b0;
    endtask

    longint t1, t2, td;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[12'h100 + i] = 8'(64'h1122334455667788 >> (8*i));
        in_rst = 1'b1; in_req_valid = 1'b0; in_req_we = 1'b0;
        in_funct3 = 3'b000; in_addr = '0; in_wdata = '0;
        repeat (3) @(negedge in_clk);
        chk("rst_ready", 64'(out_req_ready), 64'd1);
        chk("rst_resp_valid", 64'(out_resp_valid), 64'd0);
        chk("rst_resp_err", 64'(out_resp_err), 64'd0);
        chk("rst_wr_en", 64'(out_mem_wr_en), 64'd0);
        chk("rst_rdata", out_rdata, 64'd0);
        chk("rst_mem_addr", out_mem_addr, 64'd0);
        chk("rst_mem_wdata", out_mem_wdata, 64'd0);
        in_rst = 1'b0;
        @(negedge in_clk);

        issue(0, 3'b000, 64'h100, 0, 0, 0, 0, 64'hFFFFFFFFFFFFFF88, 1, 0, td);
        chk("busy_ready", 64'(out_req_ready), 64'd0);
        issue(0, 3'b100, 64'h100, 0, 0, 0, 0, 64'h88, 1, 0, td);
        issue(0, 3'b001, 64'h100, 0, 0, 0, 0, 64'h7788, 1, 0, td);
        issue(0, 3'b010, 64'h100, 0, 0, 0, 0, 64'h55667788, 1, 0, td);
        issue(0, 3'b011, 64'h100, 0, 0, 0, 0, 64'h1122334455667788, 1, 0, td);

        issue(1, 3'b001, 64'h100, 64'hABCD, 1, 64'h112233445566ABCD, 0, 0, 1, 0, td);
        repeat (3) @(negedge in_clk);
        chk("mem_after_sh", word_at(64'h100), 64'h112233445566ABCD);

        issue(1, 3'b011, 64'h100, 64'h80000000FFFFFFFF, 1, 64'h80000000FFFFFFFF, 0, 0, 1, 0, td);
        issue(0, 3'b010, 64'h104, 0, 0, 0, 0, 64'hFFFFFFFF80000000, 1, 0, td);
        issue(0, 3'b110, 64'h104, 0, 0, 0, 0, 64'h80000000, 1, 0, td);
        issue(0, 3'b101, 64'h106, 0, 0, 0, 0, 64'h8000, 1, 0, td);
        issue(0, 3'b001, 64'h106, 0, 0, 0, 0, 64'hFFFFFFFFFFFF8000, 1, 0, td);

        issue(1, 3'b100, 64'h100, 64'h1234, 0, 0, 1, 0, 1, 0, td);
        issue(0, 3'b111, 64'h100, 0, 0, 0, 1, 0, 1, 0, td);
        repeat (3) @(negedge in_clk);
        chk("mem_after_err", word_at(64'h100), 64'h80000000FFFFFFFF);

        issue(1, 3'b000, 64'h103, 64'hFFFFFFFFFFFFFF5A, 1, 64'h000000800000005A, 0, 0, 1, 0, td);
        issue(1, 3'b010, 64'h100, 64'h0000000123456789, 1, 64'h8000000023456789, 0, 0, 1, 0, td);
        repeat (3) @(negedge in_clk);
        chk("mem_after_sw", word_at(64'h100), 64'h8000000023456789);

        issue(0, 3'b011, 64'h100, 0, 0, 0, 0, 64'h8000000023456789, 1, 1, t1);
        issue(0, 3'b100, 64'h100, 0, 0, 0, 0, 64'h89, 1, 0, t2);
        chk("b2b_accept_gap", 64'(t2 - t1), 64'd3);

        repeat (3) @(negedge in_clk);
        issue(1, 3'b011, 64'h200, 64'hDEADBEEFCAFEF00D, 0, 0, 0, 0, 0, 0, td);
        in_rst = 1'b1;
        @(negedge in_clk);
        in_rst = 1'b0;
        chk("rst_read_ready", 64'(out_req_ready), 64'd1);
        chk("rst_read_wr_en", 64'(out_mem_wr_en), 64'd0);
        repeat (4) @(negedge in_clk);
        chk("mem_after_rst", word_at(64'h200), 64'd0);
        issue(0, 3'b101, 64'h100, 0, 0, 0, 0, 64'h6789, 1, 0, td);

        for (int k = 0; k < 30 && (resp_q.size() != 0 || wr_q.size() != 0); k++) @(negedge in_clk);
        chk("resp_q_left", 64'(resp_q.size()), 64'd0);
        chk("wr_q_left", 64'(wr_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
